// File: rtl/cv32e40n_apu_pkg.sv
// Shared APU request/response types for the request buffer and its FIFO.
// Widths mirror the cv32e40p core APU configuration.
package cv32e40n_apu_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_t;

  typedef struct packed {
    logic [31:0]                 result;
    logic [APU_NUSFLAGS_CPU-1:0] flags;
  } apu_rsp_t;

endpackage

// File: rtl/cv32e40n_apu_req_fifo.sv
// In-order DEPTH-entry FIFO of APU requests; head is always the oldest entry.
// Caller guarantees no push when full and no pop when empty.
module cv32e40n_apu_req_fifo
  import cv32e40n_apu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  apu_req_t         wdata,
  output apu_req_t         head,
  output logic [CNT_W-1:0] cnt
);

  apu_req_t             mem [DEPTH];
  logic     [PTR_W-1:0] wr_ptr;
  logic     [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40n_apu_req_buffer.sv
// Decouples the core APU port from a multi-cycle responder: queues requests,
// replays them in order downstream and returns responses one cycle later.
module cv32e40n_apu_req_buffer
  import cv32e40n_apu_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              apu_req_i,
  input  logic [APU_NARGS_CPU-1:0][31:0]    apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]            apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]       apu_flags_i,
  output logic                              apu_gnt_o,
  output logic                              apu_rvalid_o,
  output logic [31:0]                       apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]       apu_flags_o,
  output logic                              acc_req_o,
  output logic [APU_NARGS_CPU-1:0][31:0]    acc_operands_o,
  output logic [APU_WOP_CPU-1:0]            acc_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]       acc_flags_o,
  input  logic                              acc_gnt_i,
  input  logic                              acc_rvalid_i,
  input  logic [31:0]                       acc_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]       acc_flags_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned IF_W  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  logic [CNT_W-1:0] fifo_cnt;
  logic [OUT_W-1:0] outstanding;
  logic [IF_W-1:0]  inflight;
  logic             push;
  logic             pop;
  logic             rsp_ok;
  logic             rsp_bad;
  apu_req_t         wdata;
  apu_req_t         head;
  apu_rsp_t         rsp_q;

  // Registered counts only: a slot freed this cycle is reusable next cycle.
  assign inflight  = IF_W'(fifo_cnt) + IF_W'(outstanding);
  assign apu_gnt_o = (fifo_cnt < CNT_W'(DEPTH)) && (inflight < IF_W'(MAX_INFLIGHT));
  assign push      = apu_req_i && apu_gnt_o;
  assign acc_req_o = (fifo_cnt != '0);
  assign pop       = acc_req_o && acc_gnt_i;
  assign rsp_ok    = acc_rvalid_i && (outstanding != '0);
  assign rsp_bad   = acc_rvalid_i && (outstanding == '0);
  assign busy_o    = (fifo_cnt != '0) || (outstanding != '0);

  assign wdata = '{operands: apu_operands_i, op: apu_op_i, flags: apu_flags_i};

  assign acc_operands_o = head.operands;
  assign acc_op_o       = head.op;
  assign acc_flags_o    = head.flags;

  assign apu_result_o = rsp_q.result;
  assign apu_flags_o  = rsp_q.flags;

  cv32e40n_apu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .head   (head),
    .cnt    (fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding  <= '0;
      apu_rvalid_o <= 1'b0;
      rsp_q        <= '0;
      err_o        <= 1'b0;
    end else begin
      case ({pop, rsp_ok})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      apu_rvalid_o <= rsp_ok;
      if (rsp_ok) rsp_q <= '{result: acc_result_i, flags: acc_flags_i};
      if (rsp_bad) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40n_apu_req_buffer.sv
// Directed bench: default instance (DEPTH=4, MAX_INFLIGHT=4) plus a
// MAX_INFLIGHT=2 instance for the inflight cap.
module tb_cv32e40n_apu_req_buffer;
  import cv32e40n_apu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic                           apu_req, apu_gnt, apu_rvalid, acc_req, acc_gnt, acc_rvalid, busy, err;
  logic [APU_NARGS_CPU-1:0][31:0] apu_operands, acc_operands;
  logic [APU_WOP_CPU-1:0]         apu_op, acc_op;
  logic [APU_NDSFLAGS_CPU-1:0]    apu_flags, acc_flags;
  logic [31:0]                    apu_result, acc_result;
  logic [APU_NUSFLAGS_CPU-1:0]    apu_rflags, acc_rflags;

  logic                           apu_req2, apu_gnt2, apu_rvalid2, acc_req2, acc_gnt2, busy2, err2;
  logic [APU_NARGS_CPU-1:0][31:0] acc_operands2;
  logic [APU_WOP_CPU-1:0]         acc_op2;
  logic [APU_NDSFLAGS_CPU-1:0]    acc_flags2;
  logic [31:0]                    apu_result2;
  logic [APU_NUSFLAGS_CPU-1:0]    apu_rflags2;

  int checks = 0;
  int failures = 0;

  cv32e40n_apu_req_buffer #(.DEPTH(4), .MAX_INFLIGHT(4)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .apu_req_i(apu_req), .apu_operands_i(apu_operands), .apu_op_i(apu_op), .apu_flags_i(apu_flags),
    .apu_gnt_o(apu_gnt), .apu_rvalid_o(apu_rvalid), .apu_result_o(apu_result), .apu_flags_o(apu_rflags),
    .acc_req_o(acc_req), .acc_operands_o(acc_operands), .acc_op_o(acc_op), .acc_flags_o(acc_flags),
    .acc_gnt_i(acc_gnt), .acc_rvalid_i(acc_rvalid), .acc_result_i(acc_result), .acc_flags_i(acc_rflags),
    .busy_o(busy), .err_o(err)
  );

  cv32e40n_apu_req_buffer #(.DEPTH(4), .MAX_INFLIGHT(2)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .apu_req_i(apu_req2), .apu_operands_i(apu_operands), .apu_op_i(apu_op), .apu_flags_i(apu_flags),
    .apu_gnt_o(apu_gnt2), .apu_rvalid_o(apu_rvalid2), .apu_result_o(apu_result2), .apu_flags_o(apu_rflags2),
    .acc_req_o(acc_req2), .acc_operands_o(acc_operands2), .acc_op_o(acc_op2), .acc_flags_o(acc_flags2),
    .acc_gnt_i(acc_gnt2), .acc_rvalid_i(1'b0), .acc_result_i(32'h0), .acc_flags_i('0),
    .busy_o(busy2), .err_o(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    apu_req = 0; apu_req2 = 0; acc_gnt = 0; acc_gnt2 = 0; acc_rvalid = 0;
    apu_operands = '0; apu_op = '0; apu_flags = '0; acc_result = '0; acc_rflags = '0;
    #2;
    chk("rst_rvalid", 32'(apu_rvalid), 0);
    chk("rst_result", apu_result, 0);
    chk("rst_acc_req", 32'(acc_req), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(apu_gnt), 1);
    #20 rst_ni = 1'b1;
    tick();

    // Single op
    apu_req = 1; apu_op = 5; apu_operands[0] = 1; apu_operands[1] = 2; apu_operands[2] = 3;
    chk("s_gnt", 32'(apu_gnt), 1);
    chk("s_no_bypass", 32'(acc_req), 0);
    tick();
    apu_req = 0;
    chk("s_acc_req", 32'(acc_req), 1);
    chk("s_acc_op", 32'(acc_op), 5);
    chk("s_acc_opnd2", acc_operands[2], 3);
    chk("s_acc_opnd0", acc_operands[0], 1);
    chk("s_busy", 32'(busy), 1);
    acc_gnt = 1;
    tick();
    acc_gnt = 0;
    chk("s_acc_req_pop", 32'(acc_req), 0);
    chk("s_busy_out", 32'(busy), 1);
    tick();
    acc_rvalid = 1; acc_result = 32'hCAFE; acc_rflags = 5'h3;
    chk("s_rvalid_early", 32'(apu_rvalid), 0);
    tick();
    acc_rvalid = 0;
    chk("s_rvalid", 32'(apu_rvalid), 1);
    chk("s_result", apu_result, 32'hCAFE);
    chk("s_rflags", 32'(apu_rflags), 3);
    chk("s_busy_done", 32'(busy), 0);
    tick();
    chk("s_rvalid_pulse", 32'(apu_rvalid), 0);
    chk("s_result_hold", apu_result, 32'hCAFE);

    // Back-to-back: four grants with the responder stalled
    apu_req = 1;
    for (int i = 1; i <= 4; i++) begin
      apu_op = 6'(i);
      chk("b_gnt", 32'(apu_gnt), 1);
      tick();
    end
    apu_op = 9;
    chk("b_full", 32'(apu_gnt), 0);
    acc_gnt = 1;
    chk("b_head1", 32'(acc_op), 1);
    chk("b_pop_no_free", 32'(apu_gnt), 0);
    tick();
    acc_gnt = 0;
    chk("b_cap", 32'(apu_gnt), 0);
    acc_rvalid = 1; acc_result = 32'h77;
    chk("b_rsp_no_free", 32'(apu_gnt), 0);
    tick();
    acc_rvalid = 0;
    chk("b_freed", 32'(apu_gnt), 1);
    chk("b_rsp77", apu_result, 32'h77);
    tick();
    apu_req = 0;

    // Drain in order, then ordered responses
    acc_gnt = 1;
    chk("o_head2", 32'(acc_op), 2); tick();
    chk("o_head3", 32'(acc_op), 3); tick();
    chk("o_head4", 32'(acc_op), 4); tick();
    chk("o_head9", 32'(acc_op), 9); tick();
    acc_gnt = 0;
    chk("o_empty", 32'(acc_req), 0);
    chk("o_cap", 32'(apu_gnt), 0);
    chk("o_busy", 32'(busy), 1);
    acc_rvalid = 1; acc_result = 32'h11; tick();
    acc_result = 32'h22;
    chk("o_v1", 32'(apu_rvalid), 1); chk("o_r1", apu_result, 32'h11); tick();
    acc_result = 32'h33;
    chk("o_v2", 32'(apu_rvalid), 1); chk("o_r2", apu_result, 32'h22); tick();
    acc_result = 32'h44;
    chk("o_v3", 32'(apu_rvalid), 1); chk("o_r3", apu_result, 32'h33); tick();
    acc_rvalid = 0;
    chk("o_v4", 32'(apu_rvalid), 1); chk("o_r4", apu_result, 32'h44); tick();
    chk("o_idle_v", 32'(apu_rvalid), 0);
    chk("o_idle_busy", 32'(busy), 0);
    chk("o_no_err", 32'(err), 0);

    // MAX_INFLIGHT=2 instance, responder silent
    apu_req2 = 1;
    chk("m_gnt1", 32'(apu_gnt2), 1); tick();
    chk("m_gnt2", 32'(apu_gnt2), 1); tick();
    chk("m_stall", 32'(apu_gnt2), 0);
    chk("m_busy", 32'(busy2), 1);
    acc_gnt2 = 1; tick();
    acc_gnt2 = 0;
    chk("m_stall_pop", 32'(apu_gnt2), 0);
    chk("m_acc_req", 32'(acc_req2), 1);
    tick();
    chk("m_stall_hold", 32'(apu_gnt2), 0);
    apu_req2 = 0;

    // Spurious response while idle
    acc_rvalid = 1; acc_result = 32'hBAD; tick();
    acc_rvalid = 0;
    chk("e_no_rvalid", 32'(apu_rvalid), 0);
    chk("e_err", 32'(err), 1);
    chk("e_result_hold", apu_result, 32'h44);
    tick(); tick();
    chk("e_sticky", 32'(err), 1);

    // Reset mid-operation: 3 queued, 1 outstanding
    rst_ni = 0; #1;
    chk("r_err_clear", 32'(err), 0);
    rst_ni = 1;
    tick();
    apu_req = 1; apu_op = 1; tick();
    apu_op = 2; acc_gnt = 1; tick();
    acc_gnt = 0; apu_op = 3; tick();
    apu_op = 4; tick();
    apu_req = 0;
    chk("r_full_cap", 32'(apu_gnt), 0);
    chk("r_busy_pre", 32'(busy), 1);
    #2 rst_ni = 0; #1;
    chk("r_acc_req", 32'(acc_req), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_rvalid", 32'(apu_rvalid), 0);
    chk("r_result", apu_result, 0);
    chk("r_err", 32'(err), 0);
    rst_ni = 1;
    tick();
    acc_rvalid = 1; acc_result = 32'h55; tick();
    acc_rvalid = 0;
    chk("r_late_no_rvalid", 32'(apu_rvalid), 0);
    chk("r_late_err", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
